// File: rtl/updown_counter_p_if.sv
// Control and status bundle for updown_counter_p: the master drives the controls,
// the counter (slave) returns the count and its boundary flags.
interface updown_counter_p_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 3
);
  logic              load;
  logic              ce;
  logic              up_down;
  logic              sat_mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  data_load;
  logic [WIDTH-1:0]  count_out;
  logic              max_count;
  logic              zero;
  logic              ovf;
  logic              unf;

  modport master (
    output load, ce, up_down, sat_mode, step, limit, data_load,
    input  count_out, max_count, zero, ovf, unf
  );

  modport slave (
    input  load, ce, up_down, sat_mode, step, limit, data_load,
    output count_out, max_count, zero, ovf, unf
  );
endinterface

// File: rtl/updown_counter_p.sv
// Programmable up/down counter over the range 0..limit. It wraps or saturates at
// either end and raises a one-cycle ovf/unf pulse on each boundary event.
module updown_counter_p #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  updown_counter_p_if.slave   bus
);
  localparam int EW = WIDTH + 1;

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [EW-1:0]    w_cnt;
  logic [EW-1:0]    w_lim;
  logic [EW-1:0]    w_step;
  logic [EW-1:0]    w_s;
  logic [EW-1:0]    w_sum;
  logic [EW-1:0]    w_next;
  logic [WIDTH-1:0] w_load_val;
  logic             w_ovf;
  logic             w_unf;

  // One extra bit lets count+step and count+limit+1 be formed without truncation.
  assign w_cnt      = {1'b0, r_count};
  assign w_lim      = {1'b0, bus.limit};
  assign w_step     = {{(EW-STEP_W){1'b0}}, bus.step};
  assign w_s        = (w_step < w_lim) ? w_step : w_lim;
  assign w_sum      = w_cnt + w_s;
  assign w_load_val = (bus.data_load > bus.limit) ? bus.limit : bus.data_load;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_next = w_cnt;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    if (w_s == '0) begin
      w_next = w_cnt;
    end else if (w_cnt > w_lim) begin
      // The limit dropped under the count: up counts as an overflow, down lands on limit.
      if (bus.up_down) begin
        w_next = bus.sat_mode ? w_lim : '0;
        w_ovf  = 1'b1;
      end else begin
        w_next = w_lim;
      end
    end else if (bus.up_down) begin
      if (w_sum > w_lim) begin
        w_next = bus.sat_mode ? w_lim : (w_sum - (w_lim + 1'b1));
        w_ovf  = 1'b1;
      end else begin
        w_next = w_sum;
      end
    end else begin
      if (w_cnt >= w_s) begin
        w_next = w_cnt - w_s;
      end else begin
        w_next = bus.sat_mode ? '0 : (w_cnt + w_lim + 1'b1 - w_s);
        w_unf  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (bus.load) begin
      r_count <= w_load_val;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (bus.ce) begin
      r_count <= w_next[WIDTH-1:0];
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
    end else begin
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end
  end

  assign bus.count_out = r_count;
  assign bus.max_count = (r_count == bus.limit);
  assign bus.zero      = (r_count == '0);
  assign bus.ovf       = r_ovf;
  assign bus.unf       = r_unf;
endmodule

// File: tb/tb_updown_counter_p.sv
// Directed bench for updown_counter_p: stimulus pushes hand-computed expectations
// into a queue, and a monitor compares them one clock edge later.
module tb_updown_counter_p;
  logic clk;
  logic rst;

  updown_counter_p_if #(.WIDTH(4), .STEP_W(3)) bus ();

  updown_counter_p #(.WIDTH(4), .STEP_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] cnt;
    logic       mx;
    logic       zr;
    logic       ov;
    logic       un;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge and queue the state expected after the next rising edge.
  task automatic cyc(input logic r, input logic ld, input logic c, input logic ud, input logic sm,
                     input logic [2:0] st, input logic [3:0] lim, input logic [3:0] dl,
                     input logic [3:0] ec, input logic eo, input logic eu, input string nm);
    exp_t e;
    @(negedge clk);
    rst           = r;
    bus.load      = ld;
    bus.ce        = c;
    bus.up_down   = ud;
    bus.sat_mode  = sm;
    bus.step      = st;
    bus.limit     = lim;
    bus.data_load = dl;
    e.cnt  = ec;
    e.mx   = (ec == lim);
    e.zr   = (ec == 4'd0);
    e.ov   = eo;
    e.un   = eu;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: a rising edge with a queued expectation is checked 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({bus.count_out, bus.max_count, bus.zero, bus.ovf, bus.unf} !==
            {e.cnt, e.mx, e.zr, e.ov, e.un}) begin
          bad++;
          $display("FAIL %s: got cnt=%0d max=%b zero=%b ovf=%b unf=%b, want cnt=%0d max=%b zero=%b ovf=%b unf=%b",
                   e.name, bus.count_out, bus.max_count, bus.zero, bus.ovf, bus.unf,
                   e.cnt, e.mx, e.zr, e.ov, e.un);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bus.load = 1'b0; bus.ce = 1'b0; bus.up_down = 1'b0;
    bus.sat_mode = 1'b0; bus.step = '0; bus.limit = '0; bus.data_load = '0;

    //  rst ld ce ud sm step lim dl  cnt ovf unf
    cyc(1, 1, 1, 1, 0, 3'd1, 4'd9,  4'd5,  4'd0,  0, 0, "reset");
    // Wrap up at limit 9
    cyc(0, 1, 0, 1, 0, 3'd1, 4'd9,  4'd8,  4'd8,  0, 0, "wrap_up_load");
    cyc(0, 0, 1, 1, 0, 3'd1, 4'd9,  4'd0,  4'd9,  0, 0, "wrap_up_to_lim");
    cyc(0, 0, 1, 1, 0, 3'd1, 4'd9,  4'd0,  4'd0,  1, 0, "wrap_up_ovf");
    cyc(0, 0, 0, 1, 0, 3'd1, 4'd9,  4'd0,  4'd0,  0, 0, "hold_clears_ovf");
    // Saturate up at 15
    cyc(0, 1, 0, 1, 1, 3'd3, 4'd15, 4'd14, 4'd14, 0, 0, "sat_up_load");
    cyc(0, 0, 1, 1, 1, 3'd3, 4'd15, 4'd0,  4'd15, 1, 0, "sat_up_ovf1");
    cyc(0, 0, 1, 1, 1, 3'd3, 4'd15, 4'd0,  4'd15, 1, 0, "sat_up_ovf2");
    // Wrap down at limit 9
    cyc(0, 1, 0, 0, 0, 3'd3, 4'd9,  4'd1,  4'd1,  0, 0, "wrap_dn_load");
    cyc(0, 0, 1, 0, 0, 3'd3, 4'd9,  4'd0,  4'd8,  0, 1, "wrap_dn_unf");
    cyc(0, 0, 1, 0, 0, 3'd3, 4'd9,  4'd0,  4'd5,  0, 0, "wrap_dn_plain");
    // Load clamps to limit and beats ce
    cyc(0, 1, 1, 1, 0, 3'd3, 4'd9,  4'd12, 4'd9,  0, 0, "load_clamp");
    // Limit shrink below the count
    cyc(0, 1, 0, 1, 0, 3'd1, 4'd15, 4'd12, 4'd12, 0, 0, "shrink_load_a");
    cyc(0, 0, 1, 1, 0, 3'd1, 4'd5,  4'd0,  4'd0,  1, 0, "shrink_up_wrap");
    cyc(0, 1, 0, 0, 0, 3'd1, 4'd15, 4'd12, 4'd12, 0, 0, "shrink_load_b");
    cyc(0, 0, 1, 0, 0, 3'd1, 4'd5,  4'd0,  4'd5,  0, 0, "shrink_down");
    cyc(0, 1, 0, 1, 1, 3'd1, 4'd15, 4'd12, 4'd12, 0, 0, "shrink_load_c");
    cyc(0, 0, 1, 1, 1, 3'd1, 4'd5,  4'd0,  4'd5,  1, 0, "shrink_up_sat");
    // Saturate down at 0
    cyc(0, 1, 0, 0, 1, 3'd3, 4'd9,  4'd1,  4'd1,  0, 0, "sat_dn_load");
    cyc(0, 0, 1, 0, 1, 3'd3, 4'd9,  4'd0,  4'd0,  0, 1, "sat_dn_unf1");
    cyc(0, 0, 1, 0, 1, 3'd3, 4'd9,  4'd0,  4'd0,  0, 1, "sat_dn_unf2");
    // Zero step holds silently
    cyc(0, 1, 0, 1, 0, 3'd0, 4'd9,  4'd4,  4'd4,  0, 0, "step0_load");
    cyc(0, 0, 1, 1, 0, 3'd0, 4'd9,  4'd0,  4'd4,  0, 0, "step0_hold");
    // Step larger than limit is clipped to limit
    cyc(0, 1, 0, 1, 0, 3'd7, 4'd2,  4'd1,  4'd1,  0, 0, "clip_load");
    cyc(0, 0, 1, 1, 0, 3'd7, 4'd2,  4'd0,  4'd0,  1, 0, "clip_up_wrap");
    // limit = 0
    cyc(0, 1, 0, 1, 0, 3'd5, 4'd0,  4'd5,  4'd0,  0, 0, "lim0_load");
    cyc(0, 0, 1, 1, 0, 3'd5, 4'd0,  4'd0,  4'd0,  0, 0, "lim0_up");
    cyc(0, 0, 1, 0, 0, 3'd5, 4'd0,  4'd0,  4'd0,  0, 0, "lim0_down");
    // Sums past 2^WIDTH must not truncate
    cyc(0, 1, 0, 1, 0, 3'd3, 4'd15, 4'd13, 4'd13, 0, 0, "wide_load");
    cyc(0, 0, 1, 1, 0, 3'd3, 4'd15, 4'd0,  4'd0,  1, 0, "wide_up_wrap");
    cyc(0, 1, 0, 0, 1, 3'd5, 4'd15, 4'd2,  4'd2,  0, 0, "sat_dn2_load");
    cyc(0, 0, 1, 0, 1, 3'd5, 4'd15, 4'd0,  4'd0,  0, 1, "sat_dn2_unf");
    // Reset aborts a count that would have overflowed
    cyc(0, 1, 0, 1, 0, 3'd1, 4'd9,  4'd9,  4'd9,  0, 0, "abort_load");
    cyc(1, 0, 1, 1, 0, 3'd1, 4'd9,  4'd0,  4'd0,  0, 0, "abort_reset");
    cyc(0, 0, 0, 1, 0, 3'd1, 4'd9,  4'd0,  4'd0,  0, 0, "abort_no_flag");

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/updown_counter_p.md
UPDOWN_COUNTER_P -- requirements
Module: updown_counter_p

Interface
REQ-001 Parameter WIDTH, default 4, counter and data width in bits (legal 2..32).
REQ-002 Parameter STEP_W, default 3, width of the step input (legal 1..WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load  input  1  active-high synchronous load of data_load.
REQ-006 ce  input  1  count enable.
REQ-007 up_down  input  1  direction: 1 = up, 0 = down.
REQ-008 sat_mode  input  1  boundary mode: 1 = saturate, 0 = wrap.
REQ-009 step  input  STEP_W  increment/decrement amount per enabled cycle.
REQ-010 limit  input  WIDTH  programmable terminal count; legal range 0..limit.
REQ-011 data_load  input  WIDTH  value for load.
REQ-012 count_out  output  WIDTH  registered count.
REQ-013 max_count  output  1  combinational, (count_out == limit).
REQ-014 zero  output  1  combinational, (count_out == 0).
REQ-015 ovf  output  1  registered one-cycle pulse on an up-direction boundary event.
REQ-016 unf  output  1  registered one-cycle pulse on a down-direction boundary event.

Function
REQ-017 Priority each edge: rst > load > ce > hold.
REQ-018 load=1: count_out <= min(data_load, limit); ovf=unf=0; direction and ce are ignored.
REQ-019 ce=0 and load=0: count_out holds; ovf=unf=0.
REQ-020 Effective step s = min(step, limit); step=0 holds the count with no flags asserted.
REQ-021 Arithmetic is computed in WIDTH+1 bits; no intermediate truncation is permitted.
REQ-022 Up, count_out + s <= limit: next = count_out + s, ovf=0.
REQ-023 Up, count_out + s > limit: wrap gives next = count_out + s - (limit+1); saturate gives next = limit; ovf=1 for one cycle in both modes.
REQ-024 Down, count_out >= s: next = count_out - s, unf=0.
REQ-025 Down, count_out < s: wrap gives next = count_out + (limit+1) - s; saturate gives next = 0; unf=1 for one cycle in both modes.
REQ-026 Saturated at limit with up and ce held, or at 0 with down and ce held: the count holds and ovf/unf re-asserts on every enabled cycle.
REQ-027 Limit lowered below count_out, then ce=1 and load=0: up gives next = 0 in wrap mode or limit in saturate mode, with ovf=1; down gives next = limit with no flag.
REQ-028 limit=0: count_out stays 0; max_count=zero=1; an up step with step>0 asserts no flag because s=0.
REQ-029 sat_mode, up_down, step and limit are sampled every cycle and take effect on the same edge; no pipeline state.
REQ-030 Latency: one clock from an input change to count_out, ovf or unf; max_count and zero follow count_out and limit combinationally.

Reset
REQ-031 rst=1 at an edge: count_out=0, ovf=0, unf=0, regardless of load or ce.
REQ-032 After reset: zero=1 and max_count=(limit==0).
REQ-033 Reset asserted mid-count aborts the operation with no flag pulse on the following cycle.

Verification (WIDTH=4, STEP_W=3)
REQ-034 Reset: rst=1 with ce=1, load=1, data_load=5 -> count_out=0, zero=1, ovf=unf=0.
REQ-035 Wrap up: limit=9, step=1, sat_mode=0, load 8, up for 2 cycles -> 9 (max_count=1), then 0 with ovf=1 for 1 cycle.
REQ-036 Saturate up: limit=15, step=3, sat_mode=1, load 14, up for 2 cycles -> 15 with ovf=1, then 15 with ovf=1 again.
REQ-037 Wrap down: limit=9, step=3, sat_mode=0, load 1, down for 1 cycle -> 8 with unf=1; next cycle -> 5 with unf=0.
REQ-038 Load clamp and priority: limit=9, data_load=12, load=1, ce=1, up -> count_out=9, ovf=0.
REQ-039 Limit shrink: count_out=12, set limit=5, up with sat_mode=0 -> 0 with ovf=1; repeat from 12 with down -> 5 with no flag.
